gfx256_cuvz_arb: RTL



---
 rtl/gfx256_pkg.sv | 13 +
 rtl/gfx256_rr_pick.sv | 29 ++
 rtl/gfx256_cuvz_arb.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gfx256_pkg.sv
// rtl/gfx256_pkg.sv - shared types and constants for the gfx256 colour/UV/Z arbiter
package gfx256_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE
   } cuvz_arb_state_t;

   localparam int CUVZ_ARB_TIMEOUT_DFLT = 1023;

endpackage

// File: rtl/gfx256_rr_pick.sv
// rtl/gfx256_rr_pick.sv - combinational round-robin picker: first set req above last (mod NREQ)
module gfx256_rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   int k;

   // Scan from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      k     = 0;
      for (int i = NREQ; i >= 1; i--) begin
         k = (int'(last) + i) % NREQ;
         if (req[k]) begin
            grant    = '0;
            grant[k] = 1'b1;
            idx      = IW'(k);
         end
      end
   end

endmodule

// File: rtl/gfx256_cuvz_arb.sv
// rtl/gfx256_cuvz_arb.sv - round-robin sequencer sharing one colour/UV/Z interpolator
// Optional WAIT timeout enabled by defining GFX256_CUVZ_ARB_TIMEOUT_EN.
module gfx256_cuvz_arb
   import gfx256_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int point_width = 16,
   parameter int TIMEOUT     = CUVZ_ARB_TIMEOUT_DFLT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NREQ-1:0]             req_i,
   input  logic [NREQ*point_width-1:0] factor0_i,
   input  logic [NREQ*point_width-1:0] factor1_i,
   input  logic [NREQ*point_width-1:0] x_i,
   input  logic [NREQ*point_width-1:0] y_i,
   output logic [NREQ-1:0]             grant_o,
   output logic [NREQ-1:0]             ack_o,
   output logic                        busy_o,
   output logic                        cu_write_o,
   output logic [point_width-1:0]      cu_factor0_o,
   output logic [point_width-1:0]      cu_factor1_o,
   output logic [point_width-1:0]      cu_x_o,
   output logic [point_width-1:0]      cu_y_o,
   input  logic                        cu_ack_i,
   output logic                        timeout_o
);

   localparam int IW = $clog2(NREQ);

   cuvz_arb_state_t        state_q, state_d;
   logic [IW-1:0]          last_q, last_d;
   logic [IW-1:0]          gidx_q, gidx_d;
   logic [NREQ-1:0]        grant_d, ack_d;
   logic                   busy_d, write_d, to_d;
   logic [point_width-1:0] f0_d, f1_d, x_d, y_d;
   logic [NREQ-1:0]        pick_grant;
   logic [IW-1:0]          pick_idx;
   logic                   expire;

   gfx256_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (req_i),
      .last  (last_q),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

`ifdef GFX256_CUVZ_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one.
   assign expire = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      grant_d = grant_o;
      ack_d   = '0;
      write_d = 1'b0;
      to_d    = 1'b0;
      f0_d    = cu_factor0_o;
      f1_d    = cu_factor1_o;
      x_d     = cu_x_o;
      y_d     = cu_y_o;
`ifdef GFX256_CUVZ_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               grant_d = pick_grant;
               gidx_d  = pick_idx;
               f0_d    = factor0_i[pick_idx*point_width +: point_width];
               f1_d    = factor1_i[pick_idx*point_width +: point_width];
               x_d     = x_i[pick_idx*point_width +: point_width];
               y_d     = y_i[pick_idx*point_width +: point_width];
               write_d = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT;
`ifdef GFX256_CUVZ_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (cu_ack_i || expire) begin
               ack_d   = grant_o;
               to_d    = !cu_ack_i;
               grant_d = '0;
               last_d  = gidx_q;
               state_d = DONE;
            end
`ifdef GFX256_CUVZ_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q       <= IW'(NREQ - 1);
         gidx_q       <= '0;
         grant_o      <= '0;
         ack_o        <= '0;
         busy_o       <= 1'b0;
         cu_write_o   <= 1'b0;
         timeout_o    <= 1'b0;
         cu_factor0_o <= '0;
         cu_factor1_o <= '0;
         cu_x_o       <= '0;
         cu_y_o       <= '0;
      end else begin
         last_q       <= last_d;
         gidx_q       <= gidx_d;
         grant_o      <= grant_d;
         ack_o        <= ack_d;
         busy_o       <= busy_d;
         cu_write_o   <= write_d;
         timeout_o    <= to_d;
         cu_factor0_o <= f0_d;
         cu_factor1_o <= f1_d;
         cu_x_o       <= x_d;
         cu_y_o       <= y_d;
      end
   end

endmodule
